boot_sequencer: RTL and testbench
=================================

Name: boot_sequencer

Overview:
- Hardware boot/run controller for the rv32c core.
- Accepts a stream of HALF_WIDTH-bit instruction halfwords and packs them little-endian into WORD_WIDTH-bit memory words. The first halfword received goes in the low bits.
- Writes packed words into CPU instruction/data memory, holds CPU reset for a programmable time, then releases the CPU and supervises the run until halt or cycle limit.
- Sits between an external loader port and the cpu/memory pair.

Parameters:
- HALF_WIDTH, 16, width of one input halfword.
- WORD_WIDTH, 32, memory word width. Must be an integer multiple R = WORD_WIDTH/HALF_WIDTH of HALF_WIDTH, with R >= 1.
- MEM_DEPTH, 512, number of memory words.
- ADDR_WIDTH, 9, memory word address width; ceil(log2(MEM_DEPTH)).
- HOLD_CYCLES, 1, clock cycles cpu_reset stays high after load completes; minimum 1.
- RUN_CYCLES, 40, cycle limit for RUN; used only with the watchdog feature.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a load from IDLE or STOP
- in_valid  in  1  halfword available
- in_ready  out  1  sequencer accepts halfword
- in_data  in  HALF_WIDTH  instruction halfword
- in_last  in  1  marks final halfword of the image
- cpu_halt  in  1  CPU reports halt
- mem_we  out  1  memory write strobe
- mem_addr  out  ADDR_WIDTH  word address
- mem_wdata  out  WORD_WIDTH  packed word
- cpu_reset  out  1  active-high reset to cpu
- loaded_words  out  ADDR_WIDTH+1  words written this load
- overflow  out  1  image exceeded MEM_DEPTH
- done  out  1  run finished
- timeout  out  1  run ended by watchdog

Behaviour:
- Reset (reset=0, asynchronous) values:
  - state=IDLE; in_ready=0; mem_we=0; mem_addr=0; mem_wdata=0.
  - cpu_reset=1; loaded_words=0; overflow=0; done=0; timeout=0.
  - Pack counter and hold/run counters cleared.
- Reset asserted mid-operation aborts immediately. Partially packed data is discarded; no write is issued.
- States: IDLE, LOAD, HOLD, RUN, STOP.
- IDLE:
  - cpu_reset=1, in_ready=0.
  - On start: clear loaded_words, overflow, done, timeout, pack counter and address; go to LOAD.
- LOAD:
  - in_ready=1, cpu_reset=1.
  - A halfword is accepted when in_valid & in_ready. It is stored in slot k of the pack register, bits [k*HALF_WIDTH +: HALF_WIDTH]. k increments 0..R-1.
  - When slot R-1 is filled, or in_last is accepted:
    - Next cycle: mem_we=1 for exactly one cycle, mem_addr = current address, mem_wdata = packed word. Unfilled upper slots are zero.
    - Address then increments and loaded_words increments.
  - Writes are pipelined; in_ready stays high, so one halfword per cycle is sustained.
  - The accept that produces the write of address MEM_DEPTH-1 ends LOAD. If in_last was not asserted on that accept, set overflow=1.
  - After the final write, go to HOLD. in_ready drops the cycle after the final accept.
  - start during LOAD is ignored.
  - in_last with k=0 on an empty pack register still writes one word.
- HOLD:
  - cpu_reset=1 for HOLD_CYCLES cycles, counted from the cycle after the final mem_we.
  - Then go to RUN.
- RUN:
  - cpu_reset=0.
  - cpu_halt=1 -> STOP with done=1.
  - cpu_halt and watchdog expiry in the same cycle: halt wins, timeout=0.
- STOP:
  - cpu_reset=1; done and timeout hold their values.
  - start -> clears the flags, as from IDLE, and goes to LOAD.
  - start in RUN or HOLD is ignored.
- loaded_words saturates at MEM_DEPTH.

Optional Feature:
- Macro: BOOT_WATCHDOG_EN.
- Defined: a RUN cycle counter counts from RUN entry. After RUN_CYCLES cycles in RUN with no halt, go to STOP with done=1, timeout=1.
- Not defined: no counter is built; timeout is tied to 0; RUN ends only on cpu_halt.

Test Plan:
- R=2, stream 0x0013, 0x0001, 0x4505, 0x8082 (in_last on the 4th), one per cycle -> two writes: addr0=0x00010013, addr1=0x80824505. loaded_words=2, overflow=0. cpu_reset falls HOLD_CYCLES+1 cycles after the second mem_we.
- Odd length: 3 halfwords 0x1111, 0x2222, 0x3333 with last -> addr1=0x00003333, loaded_words=2.
- MEM_DEPTH=4, 10 halfwords, no in_last -> 4 writes, overflow=1, in_ready=0 after the 8th accept, remaining 2 halfwords not accepted.
- In RUN, cpu_halt pulsed on the 5th cycle -> STOP, done=1, timeout=0, cpu_reset=1. A subsequent start reloads with the flags cleared.
- With BOOT_WATCHDOG_EN and RUN_CYCLES=40, cpu_halt held 0 -> STOP exactly 40 cycles after RUN entry, timeout=1. cpu_halt on cycle 40 gives timeout=0.
- reset driven low mid-LOAD after 1 halfword (R=2) -> all outputs return to reset values asynchronously, no mem_we. Next start loads from addr0.

Source files
------------

// File: rtl/boot_sequencer.sv
// Boot/run controller for the rv32c core: packs loader halfwords into memory words,
// holds the CPU in reset, then supervises the run. Optional watchdog: BOOT_WATCHDOG_EN.
module boot_sequencer #(
  parameter int HALF_WIDTH  = 16,
  parameter int WORD_WIDTH  = 32,
  parameter int MEM_DEPTH   = 512,
  parameter int ADDR_WIDTH  = 9,
  parameter int HOLD_CYCLES = 1,
  parameter int RUN_CYCLES  = 40
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [HALF_WIDTH-1:0] in_data,
  input  logic                  in_last,
  input  logic                  cpu_halt,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WORD_WIDTH-1:0] mem_wdata,
  output logic                  cpu_reset,
  output logic [ADDR_WIDTH:0]   loaded_words,
  output logic                  overflow,
  output logic                  done,
  output logic                  timeout
);

  localparam int R   = WORD_WIDTH / HALF_WIDTH;
  localparam int KW  = (R > 1) ? $clog2(R) : 1;
  localparam int HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_HOLD = 3'd2;
  localparam logic [2:0] S_RUN  = 3'd3;
  localparam logic [2:0] S_STOP = 3'd4;

  logic [2:0]            state_reg;
  logic                  in_ready_reg;
  logic                  mem_we_reg;
  logic                  overflow_reg;
  logic                  done_reg;
  logic                  final_pending_reg;
  logic [ADDR_WIDTH-1:0] mem_addr_reg;
  logic [ADDR_WIDTH-1:0] waddr_reg;
  logic [WORD_WIDTH-1:0] mem_wdata_reg;
  logic [WORD_WIDTH-1:0] pack_reg;
  logic [WORD_WIDTH-1:0] pack_next;
  logic [KW-1:0]         k_reg;
  logic [HCW-1:0]        hold_cnt_reg;
  logic [ADDR_WIDTH:0]   loaded_words_reg;

  logic start_ok;
  logic accept;
  logic word_full;
  logic final_accept;
  logic wd_expire;

  assign start_ok     = start && (state_reg == S_IDLE || state_reg == S_STOP);
  assign accept       = in_valid && in_ready_reg;
  assign word_full    = accept && (in_last || k_reg == KW'(R - 1));
  // The word landing on the last address closes the image whether or not in_last came with it.
  assign final_accept = word_full && (in_last || waddr_reg == ADDR_WIDTH'(MEM_DEPTH - 1));

  // Slots above k are still zero from the last flush, so a short word is zero-padded.
  generate
    for (genvar gi = 0; gi < R; gi++) begin : g_slot
      assign pack_next[gi*HALF_WIDTH +: HALF_WIDTH] =
        (k_reg == KW'(gi)) ? in_data : pack_reg[gi*HALF_WIDTH +: HALF_WIDTH];
    end
  endgenerate

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg         <= S_IDLE;
      in_ready_reg      <= 1'b0;
      mem_we_reg        <= 1'b0;
      mem_addr_reg      <= '0;
      mem_wdata_reg     <= '0;
      waddr_reg         <= '0;
      pack_reg          <= '0;
      k_reg             <= '0;
      hold_cnt_reg      <= '0;
      loaded_words_reg  <= '0;
      overflow_reg      <= 1'b0;
      done_reg          <= 1'b0;
      final_pending_reg <= 1'b0;
    end else begin
      mem_we_reg <= 1'b0;
      if (mem_we_reg && loaded_words_reg != (ADDR_WIDTH+1)'(MEM_DEPTH))
        loaded_words_reg <= loaded_words_reg + (ADDR_WIDTH+1)'(1);

      case (state_reg)
        S_IDLE, S_STOP: begin
          if (start) begin
            state_reg         <= S_LOAD;
            in_ready_reg      <= 1'b1;
            loaded_words_reg  <= '0;
            overflow_reg      <= 1'b0;
            done_reg          <= 1'b0;
            waddr_reg         <= '0;
            pack_reg          <= '0;
            k_reg             <= '0;
            final_pending_reg <= 1'b0;
          end
        end
        S_LOAD: begin
          if (accept) begin
            if (word_full) begin
              mem_we_reg    <= 1'b1;
              mem_addr_reg  <= waddr_reg;
              mem_wdata_reg <= pack_next;
              waddr_reg     <= waddr_reg + ADDR_WIDTH'(1);
              pack_reg      <= '0;
              k_reg         <= '0;
              if (final_accept) begin
                in_ready_reg      <= 1'b0;
                final_pending_reg <= 1'b1;
                overflow_reg      <= ~in_last;
              end
            end else begin
              pack_reg <= pack_next;
              k_reg    <= k_reg + KW'(1);
            end
          end
          // Leave once the final write's strobe cycle has elapsed.
          if (final_pending_reg) begin
            state_reg         <= S_HOLD;
            final_pending_reg <= 1'b0;
            hold_cnt_reg      <= '0;
          end
        end
        S_HOLD: begin
          if (hold_cnt_reg == HCW'(HOLD_CYCLES - 1))
            state_reg <= S_RUN;
          else
            hold_cnt_reg <= hold_cnt_reg + HCW'(1);
        end
        S_RUN: begin
          if (cpu_halt || wd_expire) begin
            state_reg <= S_STOP;
            done_reg  <= 1'b1;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

`ifdef BOOT_WATCHDOG_EN
  localparam int RCW = $clog2(RUN_CYCLES + 1);

  logic [RCW-1:0] run_cnt_reg;
  logic           timeout_reg;

  assign wd_expire = (state_reg == S_RUN) && (run_cnt_reg == RCW'(RUN_CYCLES - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      run_cnt_reg <= '0;
      timeout_reg <= 1'b0;
    end else begin
      run_cnt_reg <= (state_reg == S_RUN) ? run_cnt_reg + RCW'(1) : '0;
      // A halt in the expiry cycle counts as a normal finish.
      if (start_ok)
        timeout_reg <= 1'b0;
      else if (wd_expire && !cpu_halt)
        timeout_reg <= 1'b1;
    end
  end

  assign timeout = timeout_reg;
`else
  logic unused_run_cycles;
  logic unused_start_ok;
  assign unused_run_cycles = (RUN_CYCLES > 0);
  assign unused_start_ok   = start_ok;
  assign wd_expire         = 1'b0;
  assign timeout           = 1'b0;
`endif

  assign in_ready     = in_ready_reg;
  assign mem_we       = mem_we_reg;
  assign mem_addr     = mem_addr_reg;
  assign mem_wdata    = mem_wdata_reg;
  assign cpu_reset    = (state_reg != S_RUN);
  assign loaded_words = loaded_words_reg;
  assign overflow     = overflow_reg;
  assign done         = done_reg;

endmodule

// File: tb/tb_boot_sequencer.sv
// Directed bench for boot_sequencer: table of per-cycle vectors plus hand sequences
// for overflow, watchdog/halt and asynchronous reset.
module tb_boot_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        start, in_valid, in_last, cpu_halt;
  logic [15:0] in_data;
  logic        in_ready, mem_we, cpu_reset, overflow, done, timeout;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [9:0]  loaded_words;

  logic        start4, valid4, last4, halt4;
  logic [15:0] data4;
  logic        in_ready4, mem_we4, cpu_reset4, overflow4, done4, timeout4;
  logic [1:0]  mem_addr4;
  logic [31:0] mem_wdata4;
  logic [2:0]  loaded4;

  boot_sequencer dut (
    .clock(clk), .reset(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .cpu_halt(cpu_halt), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_reset(cpu_reset),
    .loaded_words(loaded_words), .overflow(overflow), .done(done), .timeout(timeout)
  );

  boot_sequencer #(.MEM_DEPTH(4), .ADDR_WIDTH(2)) dut4 (
    .clock(clk), .reset(rst_n), .start(start4), .in_valid(valid4), .in_ready(in_ready4),
    .in_data(data4), .in_last(last4), .cpu_halt(halt4), .mem_we(mem_we4),
    .mem_addr(mem_addr4), .mem_wdata(mem_wdata4), .cpu_reset(cpu_reset4),
    .loaded_words(loaded4), .overflow(overflow4), .done(done4), .timeout(timeout4)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        start;
    logic        valid;
    logic [15:0] data;
    logic        last;
    logic        halt;
    logic        e_ready;
    logic        e_we;
    logic [8:0]  e_addr;
    logic [31:0] e_wdata;
    logic        e_cpu_reset;
    logic [9:0]  e_loaded;
    logic        e_done;
    logic        e_ovf;
  } vec_t;

  vec_t vec [18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic s, input logic v, input logic [15:0] d, input logic l,
                       input logic h);
    start    = s;
    in_valid = v;
    in_data  = d;
    in_last  = l;
    cpu_halt = h;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [31:0] exp4 [4];
    int idx, accepts, writes;
    logic acc;

    drive(0, 0, 16'h0, 0, 0);
    start4 = 0; valid4 = 0; data4 = 0; last4 = 0; halt4 = 0;

    //            st v  data      l h   rdy we addr wdata          crst ld dn ov
    vec[0]  = '{1, 0, 16'h0000, 0, 0,  1, 0, 0, 32'h00000000, 1, 0, 0, 0};
    vec[1]  = '{0, 1, 16'h0013, 0, 0,  1, 0, 0, 32'h00000000, 1, 0, 0, 0};
    vec[2]  = '{0, 1, 16'h0001, 0, 0,  1, 1, 0, 32'h00010013, 1, 0, 0, 0};
    vec[3]  = '{0, 1, 16'h4505, 0, 0,  1, 0, 0, 32'h00000000, 1, 1, 0, 0};
    vec[4]  = '{0, 1, 16'h8082, 1, 0,  0, 1, 1, 32'h80824505, 1, 1, 0, 0};
    vec[5]  = '{0, 0, 16'h0000, 0, 0,  0, 0, 0, 32'h00000000, 1, 2, 0, 0};
    vec[6]  = '{0, 0, 16'h0000, 0, 0,  0, 0, 0, 32'h00000000, 0, 2, 0, 0};
    vec[7]  = '{0, 0, 16'h0000, 0, 0,  0, 0, 0, 32'h00000000, 0, 2, 0, 0};
    vec[8]  = '{0, 0, 16'h0000, 0, 0,  0, 0, 0, 32'h00000000, 0, 2, 0, 0};
    vec[9]  = '{0, 0, 16'h0000, 0, 0,  0, 0, 0, 32'h00000000, 0, 2, 0, 0};
    vec[10] = '{0, 0, 16'h0000, 0, 0,  0, 0, 0, 32'h00000000, 0, 2, 0, 0};
    vec[11] = '{0, 0, 16'h0000, 0, 1,  0, 0, 0, 32'h00000000, 1, 2, 1, 0};
    vec[12] = '{1, 0, 16'h0000, 0, 0,  1, 0, 0, 32'h00000000, 1, 0, 0, 0};
    vec[13] = '{0, 1, 16'h1111, 0, 0,  1, 0, 0, 32'h00000000, 1, 0, 0, 0};
    vec[14] = '{0, 1, 16'h2222, 0, 0,  1, 1, 0, 32'h22221111, 1, 0, 0, 0};
    vec[15] = '{0, 1, 16'h3333, 1, 0,  0, 1, 1, 32'h00003333, 1, 1, 0, 0};
    vec[16] = '{0, 0, 16'h0000, 0, 0,  0, 0, 0, 32'h00000000, 1, 2, 0, 0};
    vec[17] = '{0, 0, 16'h0000, 0, 0,  0, 0, 0, 32'h00000000, 0, 2, 0, 0};

    exp4[0] = 32'h00020001;
    exp4[1] = 32'h00040003;
    exp4[2] = 32'h00060005;
    exp4[3] = 32'h00080007;

    // Reset state
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst.in_ready",  32'(in_ready), 0);
    check("rst.mem_we",    32'(mem_we), 0);
    check("rst.mem_addr",  32'(mem_addr), 0);
    check("rst.mem_wdata", mem_wdata, 0);
    check("rst.cpu_reset", 32'(cpu_reset), 1);
    check("rst.loaded",    32'(loaded_words), 0);
    check("rst.overflow",  32'(overflow), 0);
    check("rst.done",      32'(done), 0);
    check("rst.timeout",   32'(timeout), 0);
    rst_n = 1'b1;
    step();

    // Table: 4-halfword image, halt on 5th RUN cycle, restart with 3-halfword image
    for (int i = 0; i < 18; i++) begin
      drive(vec[i].start, vec[i].valid, vec[i].data, vec[i].last, vec[i].halt);
      step();
      $display("vec %0d: start=%0d valid=%0d data=%h last=%0d halt=%0d -> we=%0d addr=%0d wdata=%h crst=%0d ld=%0d",
               i, vec[i].start, vec[i].valid, vec[i].data, vec[i].last, vec[i].halt,
               mem_we, mem_addr, mem_wdata, cpu_reset, loaded_words);
      check($sformatf("v%0d.in_ready", i), 32'(in_ready), 32'(vec[i].e_ready));
      check($sformatf("v%0d.mem_we", i), 32'(mem_we), 32'(vec[i].e_we));
      if (vec[i].e_we) begin
        check($sformatf("v%0d.mem_addr", i), 32'(mem_addr), 32'(vec[i].e_addr));
        check($sformatf("v%0d.mem_wdata", i), mem_wdata, vec[i].e_wdata);
      end
      check($sformatf("v%0d.cpu_reset", i), 32'(cpu_reset), 32'(vec[i].e_cpu_reset));
      check($sformatf("v%0d.loaded", i), 32'(loaded_words), 32'(vec[i].e_loaded));
      check($sformatf("v%0d.done", i), 32'(done), 32'(vec[i].e_done));
      check($sformatf("v%0d.overflow", i), 32'(overflow), 32'(vec[i].e_ovf));
      check($sformatf("v%0d.timeout", i), 32'(timeout), 0);
    end
    drive(0, 0, 16'h0, 0, 0);

`ifdef BOOT_WATCHDOG_EN
    // Watchdog expiry exactly 40 cycles after RUN entry
    for (int n = 1; n <= 40; n++) begin
      step();
      if (n < 40) check($sformatf("wd.run%0d.cpu_reset", n), 32'(cpu_reset), 0);
    end
    $display("watchdog run: done=%0d timeout=%0d cpu_reset=%0d", done, timeout, cpu_reset);
    check("wd.done", 32'(done), 1);
    check("wd.timeout", 32'(timeout), 1);
    check("wd.cpu_reset", 32'(cpu_reset), 1);

    // Halt in the expiry cycle wins over the watchdog
    drive(1, 0, 16'h0, 0, 0); step();
    check("wd2.timeout_cleared", 32'(timeout), 0);
    drive(0, 1, 16'h1234, 1, 0); step();
    drive(0, 0, 16'h0, 0, 0); step(); step();
    check("wd2.run_entry", 32'(cpu_reset), 0);
    for (int n = 1; n <= 40; n++) begin
      cpu_halt = (n == 40);
      step();
    end
    cpu_halt = 0;
    $display("halt-at-expiry run: done=%0d timeout=%0d", done, timeout);
    check("wd2.done", 32'(done), 1);
    check("wd2.timeout", 32'(timeout), 0);
    check("wd2.cpu_reset", 32'(cpu_reset), 1);
`else
    // No watchdog: RUN persists until halt
    for (int n = 1; n <= 45; n++) begin
      step();
      check($sformatf("run%0d.cpu_reset", n), 32'(cpu_reset), 0);
    end
    check("run.timeout", 32'(timeout), 0);
    cpu_halt = 1; step(); cpu_halt = 0;
    $display("long run halted: done=%0d timeout=%0d", done, timeout);
    check("run.done", 32'(done), 1);
    check("run.halt_timeout", 32'(timeout), 0);
    check("run.stop_cpu_reset", 32'(cpu_reset), 1);
`endif

    // Overflow on 4-word memory: 10 halfwords streamed, no in_last
    start4 = 1; step(); start4 = 0;
    check("ovf.in_ready_start", 32'(in_ready4), 1);
    idx = 0; accepts = 0; writes = 0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      valid4 = (idx < 10);
      data4  = 16'(idx + 1);
      acc    = valid4 && in_ready4;
      step();
      if (acc) begin
        idx++;
        accepts++;
      end
      if (mem_we4) begin
        $display("ovf write: addr=%0d data=%h", mem_addr4, mem_wdata4);
        if (writes < 4) begin
          check($sformatf("ovf.w%0d.addr", writes), 32'(mem_addr4), writes);
          check($sformatf("ovf.w%0d.data", writes), mem_wdata4, exp4[writes]);
        end
        writes++;
      end
      if (acc && accepts == 8) check("ovf.in_ready_after_8", 32'(in_ready4), 0);
    end
    valid4 = 0;
    check("ovf.accepts", accepts, 8);
    check("ovf.writes", writes, 4);
    check("ovf.overflow", 32'(overflow4), 1);
    check("ovf.loaded", 32'(loaded4), 4);

    // Asynchronous reset mid-LOAD after one halfword
    drive(1, 0, 16'h0, 0, 0); step();
    drive(0, 1, 16'h5555, 0, 0); step();
    drive(0, 0, 16'h0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    $display("async reset mid-load: in_ready=%0d cpu_reset=%0d we=%0d", in_ready, cpu_reset, mem_we);
    check("arst.in_ready", 32'(in_ready), 0);
    check("arst.cpu_reset", 32'(cpu_reset), 1);
    check("arst.mem_we", 32'(mem_we), 0);
    check("arst.loaded", 32'(loaded_words), 0);
    check("arst.dut4_overflow", 32'(overflow4), 0);
    check("arst.dut4_loaded", 32'(loaded4), 0);
    @(negedge clk);
    drive(0, 1, 16'h6666, 1, 0);
    for (int n = 0; n < 2; n++) begin
      step();
      check($sformatf("arst.hold%0d.mem_we", n), 32'(mem_we), 0);
    end
    drive(0, 0, 16'h0, 0, 0);
    rst_n = 1'b1;
    step();

    drive(1, 0, 16'h0, 0, 0); step();
    drive(0, 1, 16'hAAAA, 0, 0); step();
    drive(0, 1, 16'hBBBB, 1, 0); step();
    $display("reload after reset: we=%0d addr=%0d data=%h", mem_we, mem_addr, mem_wdata);
    check("reload.mem_we", 32'(mem_we), 1);
    check("reload.mem_addr", 32'(mem_addr), 0);
    check("reload.mem_wdata", mem_wdata, 32'hBBBBAAAA);
    drive(0, 0, 16'h0, 0, 0); step();
    check("reload.loaded", 32'(loaded_words), 1);
    check("reload.overflow", 32'(overflow), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
